watch_mode_controller: RTL and testbench
========================================

# watch_mode_controller

Button-driven sequencer that generates the mode and sub-state codes consumed by the digital watch display logic: `mstate`, `cstate`, `astate` and `sstate`. It also emits single-cycle command pulses to the timekeeping, alarm and stopwatch counters. It sits between the synchronized/debounced button front end and the counter and display blocks. It owns all mode, set-field, 12/24-hour format and set-mode timeout sequencing.

## Interface
- `TIMEOUT`, default 30: `tick` pulses of button inactivity after which any set state exits to normal.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: one-cycle 1 Hz enable.
- `btn_mode`, `btn_sel`, `btn_up`, `btn_fmt`, input, 1 each: synchronized single-cycle button pulses.
- `mstate`, output, 2: 00 clock, 01 alarm, 10 stopwatch.
- `cstate`, output, 3: clock sub-state.
- `astate`, output, 3: alarm sub-state.
- `sstate`, output, 1: stopwatch state, 0 stopped, 1 running.
- `inc_hour`, `inc_min`, `clr_sec`, output, 1 each: clock set pulses.
- `ainc_hour`, `ainc_min`, `aclr_sec`, output, 1 each: alarm set pulses.
- `sw_clear`, output, 1: stopwatch clear pulse.
- `aoff`, output, 1: alarm-silence pulse.

## Operation
- Internal `fmt` bit: 0 = 24 h, 1 = 12 h. Normal code is N = 001 when fmt=0, 010 when fmt=1.
- One button is honoured per cycle, with priority mode > sel > up > fmt. Lower-priority buttons pressed in the same cycle are dropped.
- **cstate sequence**
  - 24 h: 001 → 011 (set hour) → 101 (set min) → 111 (zero sec) → 001, on `btn_sel`.
  - 12 h: 010 → 100 → 110 → 111 → 010.
  - Exit from 111 goes to N for the current fmt.
- **astate sequence**
  - 000 = alarm disabled.
  - 001/010 = enabled, with the code tracking fmt.
  - Set path is the same as cstate, entered only from 001/010 via `btn_sel`. `btn_sel` in 000 is ignored.
- **mstate=00 (clock)**
  - `btn_up` in set states pulses `inc_hour` (011/100), `inc_min` (101/110) or `clr_sec` (111).
  - `btn_up` in normal state does nothing.
  - `btn_fmt` in normal toggles fmt. cstate moves to the new N; astate also moves to the new N if it is 001/010.
  - Any button press in mstate=00 also pulses `aoff`.
- **mstate=01 (alarm)**
  - `btn_up` in 000 sets astate to N.
  - `btn_up` in 001/010 sets astate to 000.
  - `btn_up` in set states pulses `ainc_hour`, `ainc_min` or `aclr_sec`, mapped by state as in clock mode.
  - `btn_fmt` behaves as in clock mode.
- **mstate=10 (stopwatch)**
  - `btn_up` toggles `sstate`.
  - `btn_sel` with sstate=0 pulses `sw_clear`; with sstate=1 it is ignored.
  - `btn_fmt` is ignored.
- **btn_mode**
  - If the active mode's sub-state is a set state (≥011), that sub-state returns to N and mstate is unchanged.
  - Otherwise mstate advances 00 → 01 → 10 → 00.
  - sstate is preserved across mode changes; the stopwatch keeps running.
- **Timeout**
  - 6-bit inactivity counter. It clears on any honoured or dropped button pulse and on entry to or exit from a set state.
  - It increments on `tick` while the active mode is in a set state.
  - When it reaches `TIMEOUT`, the sub-state returns to N and the counter clears.
  - If `tick` and a button arrive in the same cycle, the button wins and the counter clears.
- mstate=11 is illegal. Recover to 00 with cstate N on the next clock. Illegal astate/cstate values do not occur; 000 in cstate recovers to N.

## Timing
- All outputs are registered.
- State codes update on the clk edge that samples the button, so the new code is visible in the next cycle.
- Command pulses are exactly one cycle wide and are asserted in the cycle after the button pulse.
- No pulse is emitted on the cycle that a state transition consumes.
- Reset (`reset`=0, asynchronous): mstate 00, cstate 001, astate 000, sstate 0, fmt 0, counter 0, all pulses 0.
- Reset asserted mid-set-state abandons the set state without emitting any pulse.
- Back-to-back button pulses on consecutive cycles are each honoured.

## Test plan
- Release reset, then `btn_sel` ×4 with `btn_up` after each → cstate 011, 101, 111, 001; one each of `inc_hour`, `inc_min`, `clr_sec`, one cycle after the `btn_up`.
- `btn_fmt` in clock mode with astate=001 → cstate 010, astate 010. Then `btn_sel` ×4 → cstate 100, 110, 111, 010.
- `btn_mode` → mstate 01. `btn_up` → astate 000. `btn_up` → astate 010 (fmt=1). `btn_sel` → 100. Then 30 `tick`s with no button → astate 010 on the 30th.
- mstate 10: `btn_up` → sstate 1. `btn_sel` → no `sw_clear`. `btn_mode` → mstate 00 with sstate still 1. Return to 10, `btn_up` → sstate 0. `btn_sel` → `sw_clear` high for one cycle.
- `btn_mode` and `btn_up` in the same cycle while cstate=011 → cstate 001, no `inc_hour`, mstate 00. `tick` coincident with `btn_sel` at counter 29 → no timeout.
- Assert `reset`=0 while astate=101 → all outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/watch_mode_controller.sv
// Watch mode/sub-state sequencer: turns debounced button pulses into display state codes
// and one-cycle counter command pulses, with 12/24 h format and set-mode inactivity timeout.
module watch_mode_controller #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_fmt,
  output logic [1:0] mstate,
  output logic [2:0] cstate,
  output logic [2:0] astate,
  output logic       sstate,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       ainc_hour,
  output logic       ainc_min,
  output logic       aclr_sec,
  output logic       sw_clear,
  output logic       aoff
);

  typedef enum logic [1:0] {
    M_CLOCK  = 2'b00,
    M_ALARM  = 2'b01,
    M_SWATCH = 2'b10
  } mode_e;

  localparam logic [5:0] LP_CNT_LAST = 6'(TIMEOUT - 1);
  localparam int P_SW_CLEAR = 6;
  localparam int P_AOFF     = 7;

  mode_e      r_mstate, w_mstate;
  logic [2:0] r_cstate, w_cstate, r_astate, w_astate;
  logic       r_sstate, w_sstate, r_fmt, w_fmt;
  logic [5:0] r_cnt, w_cnt;
  // {aoff, sw_clear, aclr_sec, ainc_min, ainc_hour, clr_sec, inc_min, inc_hour}
  logic [7:0] r_pls, w_pls;
  logic [2:0] w_norm, w_norm_t;
  logic       w_any;

  function automatic logic f_is_set(input logic [2:0] s);
    return s >= 3'b011;
  endfunction

  function automatic logic [2:0] f_next_set(input logic [2:0] s, input logic [2:0] n);
    case (s)
      3'b001:         return 3'b011;
      3'b010:         return 3'b100;
      3'b011:         return 3'b101;
      3'b100:         return 3'b110;
      3'b101, 3'b110: return 3'b111;
      default:        return n;
    endcase
  endfunction

  // {sec, min, hour} command for btn_up in a set state; zero in normal states
  function automatic logic [2:0] f_set_pulse(input logic [2:0] s);
    return {s == 3'b111, (s == 3'b101) || (s == 3'b110), (s == 3'b011) || (s == 3'b100)};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mstate <= M_CLOCK;
      r_cstate <= 3'b001;
      r_astate <= 3'b000;
      r_sstate <= 1'b0;
      r_fmt    <= 1'b0;
      r_cnt    <= 6'd0;
      r_pls    <= 8'd0;
    end else begin
      r_mstate <= w_mstate;
      r_cstate <= w_cstate;
      r_astate <= w_astate;
      r_sstate <= w_sstate;
      r_fmt    <= w_fmt;
      r_cnt    <= w_cnt;
      r_pls    <= w_pls;
    end
  end

  always_comb begin
    w_mstate = r_mstate;
    w_cstate = r_cstate;
    w_astate = r_astate;
    w_sstate = r_sstate;
    w_fmt    = r_fmt;
    w_pls    = 8'd0;
    w_any    = btn_mode | btn_sel | btn_up | btn_fmt;
    w_cnt    = w_any ? 6'd0 : r_cnt;
    w_norm   = r_fmt ? 3'b010 : 3'b001;
    w_norm_t = r_fmt ? 3'b001 : 3'b010;
    case (r_mstate)
      M_CLOCK: begin
        w_pls[P_AOFF] = w_any;
        if (r_cstate == 3'b000) begin
          w_cstate = w_norm;
        end else if (btn_mode) begin
          if (f_is_set(r_cstate)) w_cstate = w_norm;
          else                    w_mstate = M_ALARM;
        end else if (btn_sel) begin
          w_cstate = f_next_set(r_cstate, w_norm);
        end else if (btn_up) begin
          w_pls[2:0] = f_set_pulse(r_cstate);
        end else if (btn_fmt) begin
          if (!f_is_set(r_cstate)) begin
            w_fmt    = ~r_fmt;
            w_cstate = w_norm_t;
            if (r_astate == 3'b001 || r_astate == 3'b010) w_astate = w_norm_t;
          end
        end else if (tick && f_is_set(r_cstate)) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_cstate = w_norm;
            w_cnt    = 6'd0;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
      end
      M_ALARM: begin
        if (btn_mode) begin
          if (f_is_set(r_astate)) w_astate = w_norm;
          else                    w_mstate = M_SWATCH;
        end else if (btn_sel) begin
          if (r_astate != 3'b000) w_astate = f_next_set(r_astate, w_norm);
        end else if (btn_up) begin
          if (r_astate == 3'b000)                             w_astate = w_norm;
          else if (r_astate == 3'b001 || r_astate == 3'b010) w_astate = 3'b000;
          else                                                w_pls[5:3] = f_set_pulse(r_astate);
        end else if (btn_fmt) begin
          if (!f_is_set(r_astate)) begin
            w_fmt    = ~r_fmt;
            w_cstate = w_norm_t;
            if (r_astate != 3'b000) w_astate = w_norm_t;
          end
        end else if (tick && f_is_set(r_astate)) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_astate = w_norm;
            w_cnt    = 6'd0;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
      end
      M_SWATCH: begin
        if (btn_mode)     w_mstate = M_CLOCK;
        else if (btn_sel) w_pls[P_SW_CLEAR] = ~r_sstate;
        else if (btn_up)  w_sstate = ~r_sstate;
      end
      default: begin
        w_mstate = M_CLOCK;
        w_cstate = w_norm;
        w_cnt    = 6'd0;
      end
    endcase
  end

  assign mstate    = r_mstate;
  assign cstate    = r_cstate;
  assign astate    = r_astate;
  assign sstate    = r_sstate;
  assign inc_hour  = r_pls[0];
  assign inc_min   = r_pls[1];
  assign clr_sec   = r_pls[2];
  assign ainc_hour = r_pls[3];
  assign ainc_min  = r_pls[4];
  assign aclr_sec  = r_pls[5];
  assign sw_clear  = r_pls[P_SW_CLEAR];
  assign aoff      = r_pls[P_AOFF];

endmodule

// File: tb/tb_watch_mode_controller.sv
// Directed self-checking bench for watch_mode_controller.
module tb_watch_mode_controller;
  logic       clk, reset, tick, btn_mode, btn_sel, btn_up, btn_fmt;
  logic [1:0] mstate;
  logic [2:0] cstate, astate;
  logic       sstate, inc_hour, inc_min, clr_sec, ainc_hour, ainc_min, aclr_sec, sw_clear, aoff;
  int checks = 0;
  int errors = 0;

  watch_mode_controller #(.TIMEOUT(30)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_fmt(btn_fmt),
    .mstate(mstate), .cstate(cstate), .astate(astate), .sstate(sstate),
    .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec),
    .ainc_hour(ainc_hour), .ainc_min(ainc_min), .aclr_sec(aclr_sec),
    .sw_clear(sw_clear), .aoff(aoff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for one cycle starting at a negedge; returns at the next negedge,
  // where the registered response to this cycle is visible.
  task automatic press(input logic m, input logic s, input logic u, input logic f, input logic t);
    btn_mode = m; btn_sel = s; btn_up = u; btn_fmt = f; tick = t;
    @(negedge clk);
    btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_fmt = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_fmt = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mstate !== 2'b00) begin errors++; $display("FAIL rst_mstate got=%b exp=00", mstate); end
    checks++; if (cstate !== 3'b001) begin errors++; $display("FAIL rst_cstate got=%b exp=001", cstate); end
    checks++; if (astate !== 3'b000) begin errors++; $display("FAIL rst_astate got=%b exp=000", astate); end
    checks++; if ({sstate, inc_hour, inc_min, clr_sec, ainc_hour, ainc_min, aclr_sec, sw_clear, aoff} !== 9'd0) begin
      errors++; $display("FAIL rst_pulses got=%b exp=0", {sstate, inc_hour, inc_min, clr_sec, ainc_hour, ainc_min, aclr_sec, sw_clear, aoff}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clock_set;
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b011) begin errors++; $display("FAIL cset_sel1 got=%b exp=011", cstate); end
    press(0, 0, 1, 0, 0);
    checks++; if ({inc_hour, inc_min, clr_sec, aoff} !== 4'b1001) begin errors++; $display("FAIL cset_inc_hour got=%b exp=1001", {inc_hour, inc_min, clr_sec, aoff}); end
    press(0, 1, 0, 0, 0);
    checks++; if (inc_hour !== 1'b0) begin errors++; $display("FAIL cset_pulse_width got=%b exp=0", inc_hour); end
    checks++; if (cstate !== 3'b101) begin errors++; $display("FAIL cset_sel2 got=%b exp=101", cstate); end
    press(0, 0, 1, 0, 0);
    checks++; if ({inc_hour, inc_min, clr_sec} !== 3'b010) begin errors++; $display("FAIL cset_inc_min got=%b exp=010", {inc_hour, inc_min, clr_sec}); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b111) begin errors++; $display("FAIL cset_sel3 got=%b exp=111", cstate); end
    press(0, 0, 1, 0, 0);
    checks++; if ({inc_hour, inc_min, clr_sec} !== 3'b001) begin errors++; $display("FAIL cset_clr_sec got=%b exp=001", {inc_hour, inc_min, clr_sec}); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b001) begin errors++; $display("FAIL cset_sel4 got=%b exp=001", cstate); end
    press(0, 0, 1, 0, 0);
    checks++; if ({inc_hour, inc_min, clr_sec} !== 3'b000) begin errors++; $display("FAIL cset_up_normal got=%b exp=000", {inc_hour, inc_min, clr_sec}); end
  endtask

  task automatic test_fmt;
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++; if (astate !== 3'b001) begin errors++; $display("FAIL fmt_alarm_on got=%b exp=001", astate); end
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    checks++; if (mstate !== 2'b00) begin errors++; $display("FAIL fmt_mode_wrap got=%b exp=00", mstate); end
    press(0, 0, 0, 1, 0);
    checks++; if ({cstate, astate} !== 6'b010_010) begin errors++; $display("FAIL fmt_toggle got=%b exp=010010", {cstate, astate}); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b100) begin errors++; $display("FAIL fmt12_sel1 got=%b exp=100", cstate); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b110) begin errors++; $display("FAIL fmt12_sel2 got=%b exp=110", cstate); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b111) begin errors++; $display("FAIL fmt12_sel3 got=%b exp=111", cstate); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b010) begin errors++; $display("FAIL fmt12_sel4 got=%b exp=010", cstate); end
  endtask

  task automatic test_alarm_timeout;
    press(1, 0, 0, 0, 0);
    checks++; if (mstate !== 2'b01) begin errors++; $display("FAIL alm_mode got=%b exp=01", mstate); end
    press(0, 0, 1, 0, 0);
    checks++; if (astate !== 3'b000) begin errors++; $display("FAIL alm_off got=%b exp=000", astate); end
    checks++; if (aoff !== 1'b0) begin errors++; $display("FAIL alm_no_aoff got=%b exp=0", aoff); end
    press(0, 0, 1, 0, 0);
    checks++; if (astate !== 3'b010) begin errors++; $display("FAIL alm_on12 got=%b exp=010", astate); end
    press(0, 1, 0, 0, 0);
    checks++; if (astate !== 3'b100) begin errors++; $display("FAIL alm_sel got=%b exp=100", astate); end
    press(0, 0, 1, 0, 0);
    checks++; if ({ainc_hour, ainc_min, aclr_sec, inc_hour} !== 4'b1000) begin errors++; $display("FAIL alm_ainc_hour got=%b exp=1000", {ainc_hour, ainc_min, aclr_sec, inc_hour}); end
    for (int i = 0; i < 29; i++) press(0, 0, 0, 0, 1);
    checks++; if (astate !== 3'b100) begin errors++; $display("FAIL alm_tick29 got=%b exp=100", astate); end
    press(0, 0, 0, 0, 1);
    checks++; if (astate !== 3'b010) begin errors++; $display("FAIL alm_tick30 got=%b exp=010", astate); end
  endtask

  task automatic test_stopwatch;
    press(1, 0, 0, 0, 0);
    checks++; if (mstate !== 2'b10) begin errors++; $display("FAIL sw_mode got=%b exp=10", mstate); end
    press(0, 0, 1, 0, 0);
    checks++; if (sstate !== 1'b1) begin errors++; $display("FAIL sw_start got=%b exp=1", sstate); end
    press(0, 1, 0, 0, 0);
    checks++; if (sw_clear !== 1'b0) begin errors++; $display("FAIL sw_clear_running got=%b exp=0", sw_clear); end
    press(1, 0, 0, 0, 0);
    checks++; if ({mstate, sstate} !== 3'b001) begin errors++; $display("FAIL sw_keep_running got=%b exp=001", {mstate, sstate}); end
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++; if ({mstate, sstate} !== 3'b100) begin errors++; $display("FAIL sw_stop got=%b exp=100", {mstate, sstate}); end
    press(0, 1, 0, 0, 0);
    checks++; if (sw_clear !== 1'b1) begin errors++; $display("FAIL sw_clear_stopped got=%b exp=1", sw_clear); end
    @(negedge clk);
    checks++; if (sw_clear !== 1'b0) begin errors++; $display("FAIL sw_clear_width got=%b exp=0", sw_clear); end
  endtask

  task automatic test_priority_timeout;
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checks++; if ({mstate, cstate, astate} !== 8'b00_001_001) begin errors++; $display("FAIL pri_fmt24 got=%b exp=00001001", {mstate, cstate, astate}); end
    press(0, 1, 0, 0, 0);
    press(1, 0, 1, 0, 0);
    checks++; if ({mstate, cstate} !== 5'b00_001) begin errors++; $display("FAIL pri_mode_exit got=%b exp=00001", {mstate, cstate}); end
    checks++; if (inc_hour !== 1'b0) begin errors++; $display("FAIL pri_up_dropped got=%b exp=0", inc_hour); end
    press(0, 1, 0, 0, 0);
    for (int i = 0; i < 29; i++) press(0, 0, 0, 0, 1);
    checks++; if (cstate !== 3'b011) begin errors++; $display("FAIL to_cnt29 got=%b exp=011", cstate); end
    press(0, 1, 0, 0, 1);
    checks++; if (cstate !== 3'b101) begin errors++; $display("FAIL to_btn_wins got=%b exp=101", cstate); end
    for (int i = 0; i < 29; i++) press(0, 0, 0, 0, 1);
    checks++; if (cstate !== 3'b101) begin errors++; $display("FAIL to_cleared got=%b exp=101", cstate); end
    press(0, 0, 0, 0, 1);
    checks++; if (cstate !== 3'b001) begin errors++; $display("FAIL to_expire got=%b exp=001", cstate); end
  endtask

  task automatic test_back_to_back;
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b011) begin errors++; $display("FAIL b2b_sel1 got=%b exp=011", cstate); end
    press(0, 1, 1, 0, 0);
    checks++; if ({cstate, inc_hour, inc_min} !== 5'b101_00) begin errors++; $display("FAIL b2b_sel_up got=%b exp=10100", {cstate, inc_hour, inc_min}); end
    press(0, 0, 1, 0, 0);
    checks++; if (inc_min !== 1'b1) begin errors++; $display("FAIL b2b_inc_min got=%b exp=1", inc_min); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b111) begin errors++; $display("FAIL b2b_sel3 got=%b exp=111", cstate); end
    press(0, 1, 0, 0, 0);
    checks++; if (cstate !== 3'b001) begin errors++; $display("FAIL b2b_sel4 got=%b exp=001", cstate); end
  endtask

  task automatic test_reset_mid_set;
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    checks++; if ({mstate, astate} !== 5'b01_101) begin errors++; $display("FAIL rmid_setup got=%b exp=01101", {mstate, astate}); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({mstate, cstate, astate, sstate} !== 9'b00_001_000_0) begin errors++; $display("FAIL rmid_async got=%b exp=000010000", {mstate, cstate, astate, sstate}); end
    checks++; if ({inc_hour, inc_min, clr_sec, ainc_hour, ainc_min, aclr_sec, sw_clear, aoff} !== 8'd0) begin
      errors++; $display("FAIL rmid_pulses got=%b exp=0", {inc_hour, inc_min, clr_sec, ainc_hour, ainc_min, aclr_sec, sw_clear, aoff}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_clock_set;
    test_fmt;
    test_alarm_timeout;
    test_stopwatch;
    test_priority_timeout;
    test_back_to_back;
    test_reset_mid_set;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
